// File: rtl/uart_rx_frame_if.sv
// Receive-side bus bundle for the UART frame engine: serial line and frame config in,
// received byte and status pulses out.
interface uart_rx_frame_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESC_W    = 6
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESC_W-1:0]    Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: start detect, 2-of-3 mid-bit majority vote, LSB-first
// deserialization, parity and stop checks, registered byte/status pulses.
module uart_rx_frame #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESC_W    = 6
) (
    input  logic CLK,
    input  logic RST,
    uart_rx_frame_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                r_state,    w_state_nxt;
    logic [PRESC_W-1:0]    r_edge_cnt, w_edge_nxt;
    logic [PRESC_W-1:0]    r_presc,    w_presc_nxt;
    logic                  r_par_en,   w_par_en_nxt;
    logic                  r_par_typ,  w_par_typ_nxt;
    logic [CNT_W-1:0]      r_bit_cnt,  w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift,    w_shift_nxt;
    logic [DATA_WIDTH-1:0] r_pdata,    w_pdata_nxt;
    logic [1:0]            r_samp,     w_samp_nxt;
    logic                  r_bit,      w_bit_nxt;
    logic                  r_par_fail, w_par_fail_nxt;
    logic                  r_dv,       w_dv_nxt;
    logic                  r_pe,       w_pe_nxt;
    logic                  r_se,       w_se_nxt;

    logic [PRESC_W-1:0]    w_half;
    logic [PRESC_W-1:0]    w_last;
    logic                  w_on_last;
    logic                  w_samp0_hit;
    logic                  w_samp1_hit;
    logic                  w_samp2_hit;
    logic                  w_vote;

    assign w_half      = r_presc >> 1;
    assign w_last      = r_presc - PRESC_W'(1);
    assign w_on_last   = (r_edge_cnt == w_last);
    assign w_samp0_hit = (r_edge_cnt == w_half - PRESC_W'(1));
    assign w_samp1_hit = (r_edge_cnt == w_half);
    assign w_samp2_hit = (r_edge_cnt == w_half + PRESC_W'(1));
    // Third sample comes straight off the line so the vote is ready in the same cycle.
    assign w_vote      = (r_samp[0] & r_samp[1]) | (r_samp[0] & bus.RX_IN) | (r_samp[1] & bus.RX_IN);

    assign bus.P_DATA     = r_pdata;
    assign bus.data_valid = r_dv;
    assign bus.par_err    = r_pe;
    assign bus.stp_err    = r_se;

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_presc    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_pdata    <= '0;
            r_samp     <= '0;
            r_bit      <= 1'b0;
            r_par_fail <= 1'b0;
            r_dv       <= 1'b0;
            r_pe       <= 1'b0;
            r_se       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_edge_cnt <= w_edge_nxt;
            r_presc    <= w_presc_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_typ  <= w_par_typ_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_pdata    <= w_pdata_nxt;
            r_samp     <= w_samp_nxt;
            r_bit      <= w_bit_nxt;
            r_par_fail <= w_par_fail_nxt;
            r_dv       <= w_dv_nxt;
            r_pe       <= w_pe_nxt;
            r_se       <= w_se_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_edge_nxt     = r_edge_cnt;
        w_presc_nxt    = r_presc;
        w_par_en_nxt   = r_par_en;
        w_par_typ_nxt  = r_par_typ;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_pdata_nxt    = r_pdata;
        w_samp_nxt     = r_samp;
        w_bit_nxt      = r_bit;
        w_par_fail_nxt = r_par_fail;
        w_dv_nxt       = 1'b0;
        w_pe_nxt       = 1'b0;
        w_se_nxt       = 1'b0;

        if (r_state != S_IDLE) begin
            w_edge_nxt = w_on_last ? '0 : r_edge_cnt + PRESC_W'(1);
            if (w_samp0_hit) w_samp_nxt[0] = bus.RX_IN;
            if (w_samp1_hit) w_samp_nxt[1] = bus.RX_IN;
            if (w_samp2_hit) w_bit_nxt     = w_vote;
        end

        case (r_state)
            S_IDLE: begin
                // The detect cycle itself is edge 0 of the start bit.
                if (!bus.RX_IN) begin
                    w_state_nxt    = S_START;
                    w_edge_nxt     = PRESC_W'(1);
                    w_presc_nxt    = bus.Prescale;
                    w_par_en_nxt   = bus.PAR_EN;
                    w_par_typ_nxt  = bus.PAR_TYP;
                    w_bit_cnt_nxt  = '0;
                    w_par_fail_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_samp2_hit && w_vote) begin
                    w_state_nxt = S_IDLE;
                    w_edge_nxt  = '0;
                end else if (w_on_last) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_on_last) begin
                    w_shift_nxt = {r_bit, r_shift[DATA_WIDTH-1:1]};
                    if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_on_last) begin
                    w_par_fail_nxt = (r_bit != (^r_shift ^ r_par_typ));
                    w_pe_nxt       = w_par_fail_nxt;
                    w_state_nxt    = S_STOP;
                end
            end
            S_STOP: begin
                if (w_on_last) begin
                    w_se_nxt = ~r_bit;
                    if (!r_par_fail && r_bit) begin
                        w_pdata_nxt = r_shift;
                        w_dv_nxt    = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_edge_nxt  = '0;
            end
        endcase
    end
endmodule
